// File: rtl/fetch_if.sv
// fetch_if: controller <-> fetch datapath strobes, data bus and fetch results.
// With FETCH_BKPT_EN defined, the interface also carries bkpt_addr and bkpt_hit.
interface fetch_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              ena;
    logic [DATA_W-1:0] data;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              fetch;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] addr;
    logic              lo_phase;
    logic              instr_valid;
`ifdef FETCH_BKPT_EN
    logic [ADDR_W-1:0] bkpt_addr;
    logic              bkpt_hit;
    modport master (output ena, data, load_ir, inc_pc, load_pc, fetch, bkpt_addr,
                    input  opcode, ir_addr, pc_addr, addr, lo_phase, instr_valid, bkpt_hit);
    modport slave  (input  ena, data, load_ir, inc_pc, load_pc, fetch, bkpt_addr,
                    output opcode, ir_addr, pc_addr, addr, lo_phase, instr_valid, bkpt_hit);
`else
    modport master (output ena, data, load_ir, inc_pc, load_pc, fetch,
                    input  opcode, ir_addr, pc_addr, addr, lo_phase, instr_valid);
    modport slave  (input  ena, data, load_ir, inc_pc, load_pc, fetch,
                    output opcode, ir_addr, pc_addr, addr, lo_phase, instr_valid);
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, two-byte instruction register and address mux.
// Optional breakpoint compare is enabled with FETCH_BKPT_EN.
module fetch_unit #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.slave bus
);
    typedef enum logic {HI, LO} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2*DATA_W-1:0]   r_ir;
    logic [ADDR_W-1:0]     r_pc;
    logic                  r_valid;
    logic                  w_pc_upd;
    logic [ADDR_W-1:0]     w_pc_next;

    assign w_pc_upd  = bus.ena && (bus.load_pc || bus.inc_pc);
    assign w_pc_next = bus.load_pc ? r_ir[ADDR_W-1:0] : r_pc + 1'b1;

    // Byte-phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= HI;
        else        r_state <= w_next;
    end

    // Next byte phase: ena low resyncs to the high byte, load_ir toggles
    always_comb begin
        w_next = r_state;
        if (!bus.ena)         w_next = HI;
        else if (bus.load_ir) w_next = (r_state == HI) ? LO : HI;
    end

    // Instruction register and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else if (!bus.ena) begin
            r_valid <= 1'b0;
        end else if (bus.load_ir) begin
            if (r_state == HI) r_ir[2*DATA_W-1:DATA_W] <= bus.data;
            else               r_ir[DATA_W-1:0]        <= bus.data;
            r_valid <= (r_state == LO);
        end
    end

    // Program counter: load from old ir_addr beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc <= '0;
        else if (w_pc_upd) r_pc <= w_pc_next;
    end

`ifdef FETCH_BKPT_EN
    logic r_hit;

    // Sticky breakpoint flag, cleared by an ena-low edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       r_hit <= 1'b0;
        else if (!bus.ena)                                r_hit <= 1'b0;
        else if (w_pc_upd && w_pc_next == bus.bkpt_addr)  r_hit <= 1'b1;
    end

    assign bus.bkpt_hit = r_hit;
`endif

    assign bus.opcode      = r_ir[2*DATA_W-1:2*DATA_W-3];
    assign bus.ir_addr     = r_ir[ADDR_W-1:0];
    assign bus.pc_addr     = r_pc;
    assign bus.addr        = bus.fetch ? r_pc : r_ir[ADDR_W-1:0];
    assign bus.lo_phase    = (r_state == LO);
    assign bus.instr_valid = r_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
    localparam int AW = 13;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vecs = 0;
    int errs = 0;

    // model state: instruction bytes, pc, how many bytes of the current instruction are in
    logic [15:0]   m_ir;
    logic [AW-1:0] m_pc;
    int            m_bytes;
    logic          m_valid;
    logic          m_hit;
    logic [AW-1:0] m_bkpt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("opcode", 32'(bus.opcode), 32'(m_ir >> 13));
        chk("ir_addr", 32'(bus.ir_addr), 32'(m_ir % 16'h2000));
        chk("pc_addr", 32'(bus.pc_addr), 32'(m_pc));
        chk("addr", 32'(bus.addr), bus.fetch ? 32'(m_pc) : 32'(m_ir % 16'h2000));
        chk("lo_phase", 32'(bus.lo_phase), 32'(m_bytes == 1));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
`ifdef FETCH_BKPT_EN
        chk("bkpt_hit", 32'(bus.bkpt_hit), 32'(m_hit));
`endif
    endtask

    task automatic model_reset();
        m_ir = 16'h0; m_pc = '0; m_bytes = 0; m_valid = 1'b0; m_hit = 1'b0;
    endtask

    task automatic step(input logic en, input logic [7:0] d, input logic lir,
                        input logic inc, input logic lpc, input logic f);
        int old_addr;
        int npc;
        bus.ena = en; bus.data = d; bus.load_ir = lir; bus.inc_pc = inc;
        bus.load_pc = lpc; bus.fetch = f;
`ifdef FETCH_BKPT_EN
        bus.bkpt_addr = m_bkpt;
`endif
        @(posedge clk);
        if (!en) begin
            m_bytes = 0; m_valid = 1'b0; m_hit = 1'b0;
        end else begin
            old_addr = int'(m_ir) % 8192;
            if (lir) begin
                if (m_bytes == 0) m_ir = {d, m_ir[7:0]};
                else              m_ir = {m_ir[15:8], d};
                m_bytes = (m_bytes + 1) % 2;
                m_valid = (m_bytes == 0);
            end
            if (lpc || inc) begin
                npc = lpc ? old_addr : (int'(m_pc) + 1) % 8192;
                m_pc = AW'(npc);
                if (m_pc == m_bkpt) m_hit = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_bkpt = '1;
        bus.ena = 1'b1; bus.data = '0; bus.load_ir = 1'b0; bus.inc_pc = 1'b0;
        bus.load_pc = 1'b0; bus.fetch = 1'b1;
`ifdef FETCH_BKPT_EN
        bus.bkpt_addr = m_bkpt;
`endif
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // two-byte fetch
        step(1, 8'hA1, 1, 0, 0, 1);
        chk("t2_lo_phase", 32'(bus.lo_phase), 32'd1);
        step(1, 8'h23, 1, 1, 0, 1);
        chk("t2_opcode", 32'(bus.opcode), 32'd5);
        chk("t2_ir_addr", 32'(bus.ir_addr), 32'h123);
        chk("t2_valid", 32'(bus.instr_valid), 32'd1);
        chk("t2_pc", 32'(bus.pc_addr), 32'd1);
        chk("t2_addr_pc", 32'(bus.addr), 32'd1);
        bus.fetch = 1'b0;
        #1;
        chk("t2_addr_ir", 32'(bus.addr), 32'h123);

        // wrap
        step(1, 8'hFF, 1, 0, 0, 1);
        step(1, 8'hFF, 1, 0, 0, 1);
        step(1, 8'h00, 0, 0, 1, 1);
        chk("t3_load", 32'(bus.pc_addr), 32'h1FFF);
        step(1, 8'h00, 0, 1, 0, 1);
        chk("t3_wrap", 32'(bus.pc_addr), 32'h0);

        // jmp with load_pc and inc_pc together
        step(1, 8'hE4, 1, 0, 0, 1);
        step(1, 8'h56, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'h00, 0, 1, 0, 1);
        chk("t4_pc5", 32'(bus.pc_addr), 32'd5);
        step(1, 8'h00, 0, 1, 1, 1);
        chk("t4_jmp", 32'(bus.pc_addr), 32'h456);

        // ena drop mid-fetch
        step(1, 8'h40, 1, 0, 0, 1);
        step(0, 8'h00, 1, 1, 1, 1);
        chk("t5_pc_hold", 32'(bus.pc_addr), 32'h456);
        step(1, 8'h60, 1, 0, 0, 1);
        chk("t5_opcode", 32'(bus.opcode), 32'd3);
        chk("t5_lo_phase", 32'(bus.lo_phase), 32'd1);

        // reset mid-fetch in LO
        do_reset();
        chk("t1_pc", 32'(bus.pc_addr), 32'd0);

`ifdef FETCH_BKPT_EN
        m_bkpt = 13'd3;
        step(1, 8'h00, 0, 1, 0, 1);
        step(1, 8'h00, 0, 1, 0, 1);
        chk("t6_not_yet", 32'(bus.bkpt_hit), 32'd0);
        step(1, 8'h00, 0, 1, 0, 1);
        chk("t6_hit", 32'(bus.bkpt_hit), 32'd1);
        step(1, 8'h00, 0, 1, 0, 1);
        chk("t6_sticky", 32'(bus.bkpt_hit), 32'd1);
        chk("t6_pc", 32'(bus.pc_addr), 32'd4);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("t6_clear", 32'(bus.bkpt_hit), 32'd0);
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) m_bkpt = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 9) != 0, 8'($urandom), 1'($urandom),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
